// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB pipeline register, big-endian load extraction,
// register-file write port drive and a wrapping retire counter.
module wb_stage #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             MEMtoWB_valid,
  input  logic [31:0]      MEMtoWB_PC,
  input  logic [31:0]      MEMtoWB_ALUResult,
  input  logic [31:0]      MEMtoWB_ReadData,
  input  logic [4:0]       MEMtoWB_WriteReg,
  input  logic             MEMtoWB_RegWrite,
  input  logic             MEMtoWB_MemtoReg,
  input  logic [2:0]       MEMtoWB_LoadType,
  input  logic             stall,
  input  logic             flush,
  output logic [4:0]       WBtoID_WriteReg,
  output logic [31:0]      WBtoID_WriteData,
  output logic             WBtoID_RegWrite,
  output logic             WB_Valid,
  output logic [31:0]      WB_PC,
  output logic [CNT_W-1:0] WB_RetireCount
);

  localparam logic [2:0] LT_LW  = 3'b000;
  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LHU = 3'b010;
  localparam logic [2:0] LT_LB  = 3'b011;
  localparam logic [2:0] LT_LBU = 3'b100;

  logic             valid_q;
  logic [31:0]      pc_q;
  logic [31:0]      alu_q;
  logic [31:0]      rdata_q;
  logic [4:0]       wreg_q;
  logic             regwrite_q;
  logic             memtoreg_q;
  logic [2:0]       loadtype_q;
  logic [CNT_W-1:0] cnt_q;

  // Flush only kills valid; the remaining fields are don't-care and simply hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      alu_q      <= '0;
      rdata_q    <= '0;
      wreg_q     <= '0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      loadtype_q <= LT_LW;
      cnt_q      <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (!stall) begin
      valid_q    <= MEMtoWB_valid;
      pc_q       <= MEMtoWB_PC;
      alu_q      <= MEMtoWB_ALUResult;
      rdata_q    <= MEMtoWB_ReadData;
      wreg_q     <= MEMtoWB_WriteReg;
      regwrite_q <= MEMtoWB_RegWrite;
      memtoreg_q <= MEMtoWB_MemtoReg;
      loadtype_q <= MEMtoWB_LoadType;
      if (MEMtoWB_valid) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;

  always_comb begin
    byte_sel = rdata_q[31:24];
    case (alu_q[1:0])
      2'd0: byte_sel = rdata_q[31:24];
      2'd1: byte_sel = rdata_q[23:16];
      2'd2: byte_sel = rdata_q[15:8];
      2'd3: byte_sel = rdata_q[7:0];
      default: byte_sel = rdata_q[31:24];
    endcase
    // Halfword offset bit 0 is ignored: misaligned halves read the aligned one.
    half_sel = alu_q[1] ? rdata_q[15:0] : rdata_q[31:16];
    case (loadtype_q)
      LT_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      LT_LHU:  load_data = {16'h0000, half_sel};
      LT_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      LT_LBU:  load_data = {24'h000000, byte_sel};
      default: load_data = rdata_q;
    endcase
  end

  assign WBtoID_WriteData = memtoreg_q ? load_data : alu_q;
  assign WBtoID_WriteReg  = wreg_q;
  assign WBtoID_RegWrite  = valid_q & regwrite_q & (wreg_q != 5'd0);
  assign WB_Valid         = valid_q;
  assign WB_PC            = pc_q;
  assign WB_RetireCount   = cnt_q;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage (CNT_W=8): directed load-extraction table,
// stall/flush/reset sequences, counter wrap, and randomized model comparison.
module tb_wb_stage;

  localparam int CW = 8;

  logic          clk;
  logic          rst;
  logic          MEMtoWB_valid;
  logic [31:0]   MEMtoWB_PC;
  logic [31:0]   MEMtoWB_ALUResult;
  logic [31:0]   MEMtoWB_ReadData;
  logic [4:0]    MEMtoWB_WriteReg;
  logic          MEMtoWB_RegWrite;
  logic          MEMtoWB_MemtoReg;
  logic [2:0]    MEMtoWB_LoadType;
  logic          stall;
  logic          flush;
  logic [4:0]    WBtoID_WriteReg;
  logic [31:0]   WBtoID_WriteData;
  logic          WBtoID_RegWrite;
  logic          WB_Valid;
  logic [31:0]   WB_PC;
  logic [CW-1:0] WB_RetireCount;

  wb_stage #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .MEMtoWB_valid(MEMtoWB_valid), .MEMtoWB_PC(MEMtoWB_PC),
    .MEMtoWB_ALUResult(MEMtoWB_ALUResult), .MEMtoWB_ReadData(MEMtoWB_ReadData),
    .MEMtoWB_WriteReg(MEMtoWB_WriteReg), .MEMtoWB_RegWrite(MEMtoWB_RegWrite),
    .MEMtoWB_MemtoReg(MEMtoWB_MemtoReg), .MEMtoWB_LoadType(MEMtoWB_LoadType),
    .stall(stall), .flush(flush),
    .WBtoID_WriteReg(WBtoID_WriteReg), .WBtoID_WriteData(WBtoID_WriteData),
    .WBtoID_RegWrite(WBtoID_RegWrite), .WB_Valid(WB_Valid), .WB_PC(WB_PC),
    .WB_RetireCount(WB_RetireCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: the instruction currently held in WB plus a retire tally.
  logic        m_valid, m_rw, m_m2r;
  logic [31:0] m_pc, m_alu, m_rd;
  logic [4:0]  m_wreg;
  logic [2:0]  m_lt;
  int          m_cnt;

  initial begin
    m_valid = 0; m_rw = 0; m_m2r = 0; m_pc = 0; m_alu = 0; m_rd = 0;
    m_wreg = 0; m_lt = 0; m_cnt = 0;
  end

  function automatic logic [31:0] ref_load(logic [2:0] lt, logic [31:0] alu, logic [31:0] rd);
    logic [31:0] b, h;
    int off;
    off = int'(alu[1:0]);
    b = (rd >> (8 * (3 - off))) & 32'hFF;
    h = (rd >> (alu[1] ? 0 : 16)) & 32'hFFFF;
    case (lt)
      3'd1:    return (h >= 32'h8000) ? h + 32'hFFFF0000 : h;
      3'd2:    return h;
      3'd3:    return (b >= 32'h80) ? b + 32'hFFFFFF00 : b;
      3'd4:    return b;
      default: return rd;
    endcase
  endfunction

  function automatic logic [31:0] exp_wdata();
    return m_m2r ? ref_load(m_lt, m_alu, m_rd) : m_alu;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one clock: model consumes the current inputs, outputs sampled 1ns later.
  task automatic tick();
    if (rst) begin
      m_valid = 0; m_rw = 0; m_m2r = 0; m_pc = 0; m_alu = 0; m_rd = 0;
      m_wreg = 0; m_lt = 0; m_cnt = 0;
    end else if (flush) begin
      m_valid = 0;
    end else if (!stall) begin
      m_valid = MEMtoWB_valid; m_pc = MEMtoWB_PC; m_alu = MEMtoWB_ALUResult;
      m_rd = MEMtoWB_ReadData; m_wreg = MEMtoWB_WriteReg; m_rw = MEMtoWB_RegWrite;
      m_m2r = MEMtoWB_MemtoReg; m_lt = MEMtoWB_LoadType;
      if (MEMtoWB_valid) m_cnt = (m_cnt + 1) % (1 << CW);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic v, logic [31:0] pc, logic [31:0] alu, logic [31:0] rd,
                       logic [4:0] wr, logic rw, logic m2r, logic [2:0] lt);
    MEMtoWB_valid = v; MEMtoWB_PC = pc; MEMtoWB_ALUResult = alu;
    MEMtoWB_ReadData = rd; MEMtoWB_WriteReg = wr; MEMtoWB_RegWrite = rw;
    MEMtoWB_MemtoReg = m2r; MEMtoWB_LoadType = lt;
  endtask

  task automatic chk_model(string tag);
    chk({tag, ".valid"}, 32'(WB_Valid), 32'(m_valid));
    chk({tag, ".regwrite"}, 32'(WBtoID_RegWrite), 32'(m_valid && m_rw && m_wreg != 0));
    chk({tag, ".count"}, 32'(WB_RetireCount), 32'(m_cnt));
    if (m_valid) begin
      chk({tag, ".wreg"}, 32'(WBtoID_WriteReg), 32'(m_wreg));
      chk({tag, ".wdata"}, WBtoID_WriteData, exp_wdata());
      chk({tag, ".pc"}, WB_PC, m_pc);
    end
  endtask

  typedef struct {
    string       name;
    logic [2:0]  lt;
    logic [31:0] alu;
    logic [31:0] rd;
    logic        m2r;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int prev_cnt;
    vecs.push_back('{"lb_off1",   3'b011, 32'h0000_1001, 32'h8091A2B3, 1'b1, 32'hFFFFFF91});
    vecs.push_back('{"lbu_off3",  3'b100, 32'h0000_1003, 32'h8091A2B3, 1'b1, 32'h000000B3});
    vecs.push_back('{"lh_off0",   3'b001, 32'h0000_1000, 32'h8091A2B3, 1'b1, 32'hFFFF8091});
    vecs.push_back('{"lhu_off2",  3'b010, 32'h0000_1002, 32'h8091A2B3, 1'b1, 32'h0000A2B3});
    vecs.push_back('{"lh_off3",   3'b001, 32'h0000_1003, 32'h8091A2B3, 1'b1, 32'hFFFFA2B3});
    vecs.push_back('{"lb_off2",   3'b011, 32'h0000_2002, 32'h8091A2B3, 1'b1, 32'hFFFFFFA2});
    vecs.push_back('{"lb_off3p",  3'b011, 32'h0000_2003, 32'h8091A27F, 1'b1, 32'h0000007F});
    vecs.push_back('{"lbu_off0",  3'b100, 32'h0000_2000, 32'h8091A2B3, 1'b1, 32'h00000080});
    vecs.push_back('{"lhu_off1",  3'b010, 32'h0000_2001, 32'h8091A2B3, 1'b1, 32'h00008091});
    vecs.push_back('{"lh_pos",    3'b001, 32'h0000_2002, 32'h80917FB3, 1'b1, 32'h00007FB3});
    vecs.push_back('{"lw",        3'b000, 32'h0000_2001, 32'h8091A2B3, 1'b1, 32'h8091A2B3});
    vecs.push_back('{"code111",   3'b111, 32'h0000_2003, 32'h8091A2B3, 1'b1, 32'h8091A2B3});
    vecs.push_back('{"alu_path",  3'b011, 32'hDEAD_BEEF, 32'h8091A2B3, 1'b0, 32'hDEADBEEF});

    // Reset with busy inputs: everything must read zero.
    rst = 1; stall = 0; flush = 0;
    drive(1, 32'h1234_5678, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 1, 1, 3'b011);
    tick();
    chk("rst.regwrite", 32'(WBtoID_RegWrite), 0);
    chk("rst.wreg", 32'(WBtoID_WriteReg), 0);
    chk("rst.wdata", WBtoID_WriteData, 0);
    chk("rst.valid", 32'(WB_Valid), 0);
    chk("rst.pc", WB_PC, 0);
    chk("rst.count", 32'(WB_RetireCount), 0);
    rst = 0;

    // Plain ALU write.
    drive(1, 32'h0000_0100, 32'h0000_0005, 32'h0, 5'd8, 1, 0, 3'b000);
    tick();
    chk("alu.regwrite", 32'(WBtoID_RegWrite), 1);
    chk("alu.wreg", 32'(WBtoID_WriteReg), 8);
    chk("alu.wdata", WBtoID_WriteData, 32'h5);
    chk("alu.pc", WB_PC, 32'h100);
    chk("alu.count", 32'(WB_RetireCount), 1);

    foreach (vecs[i]) begin
      drive(1, 32'h400 + 32'(i * 4), vecs[i].alu, vecs[i].rd, 5'd10, 1, vecs[i].m2r, vecs[i].lt);
      tick();
      chk(vecs[i].name, WBtoID_WriteData, vecs[i].exp);
    end
    chk("table.count", 32'(WB_RetireCount), 32'(1 + vecs.size()));

    // Writes to $0 are suppressed but still retire.
    prev_cnt = m_cnt;
    drive(1, 32'h500, 32'h77, 32'h0, 5'd0, 1, 0, 3'b000);
    tick();
    chk("r0.regwrite", 32'(WBtoID_RegWrite), 0);
    chk("r0.valid", 32'(WB_Valid), 1);
    chk("r0.count", 32'(WB_RetireCount), 32'(prev_cnt + 1));

    // Stall three cycles while inputs keep changing.
    drive(1, 32'h600, 32'h0000_1234, 32'h0, 5'd3, 1, 0, 3'b000);
    tick();
    prev_cnt = m_cnt;
    stall = 1;
    for (int k = 0; k < 3; k++) begin
      drive(1, 32'h700 + 32'(k), 32'hAAAA_0000 + 32'(k), 32'h5555_5555, 5'd20 + 5'(k), 1, 0, 3'b000);
      tick();
      chk("stall.wdata", WBtoID_WriteData, 32'h1234);
      chk("stall.wreg", 32'(WBtoID_WriteReg), 3);
      chk("stall.pc", WB_PC, 32'h600);
      chk("stall.regwrite", 32'(WBtoID_RegWrite), 1);
      chk("stall.count", 32'(WB_RetireCount), 32'(prev_cnt));
    end
    stall = 0;
    tick();
    chk("unstall.pc", WB_PC, 32'h702);
    chk("unstall.wdata", WBtoID_WriteData, 32'hAAAA_0002);
    chk("unstall.count", 32'(WB_RetireCount), 32'(prev_cnt + 1));

    // Flush beats stall.
    prev_cnt = m_cnt;
    flush = 1; stall = 1;
    drive(1, 32'h800, 32'h9, 32'h0, 5'd4, 1, 0, 3'b000);
    tick();
    chk("flush.valid", 32'(WB_Valid), 0);
    chk("flush.regwrite", 32'(WBtoID_RegWrite), 0);
    chk("flush.count", 32'(WB_RetireCount), 32'(prev_cnt));
    flush = 0; stall = 0;

    // Reset during stall clears everything.
    tick();
    stall = 1; rst = 1;
    tick();
    chk("rststall.valid", 32'(WB_Valid), 0);
    chk("rststall.regwrite", 32'(WBtoID_RegWrite), 0);
    chk("rststall.wreg", 32'(WBtoID_WriteReg), 0);
    chk("rststall.wdata", WBtoID_WriteData, 0);
    chk("rststall.pc", WB_PC, 0);
    chk("rststall.count", 32'(WB_RetireCount), 0);
    rst = 0; stall = 0;

    // Counter wrap at 8 bits.
    for (int k = 0; k < 255; k++) begin
      drive(1, 32'(k * 4), 32'(k), 32'h0, 5'(k), k[0], 0, 3'b000);
      tick();
    end
    chk("wrap.pre", 32'(WB_RetireCount), 32'hFF);
    drive(1, 32'h0, 32'h0, 32'h0, 5'd1, 1, 0, 3'b000);
    tick();
    chk("wrap.post", 32'(WB_RetireCount), 32'h00);

    // Randomized traffic against the model.
    for (int k = 0; k < 600; k++) begin
      rst   = ($urandom_range(0, 59) == 0);
      flush = ($urandom_range(0, 7) == 0);
      stall = ($urandom_range(0, 3) == 0);
      drive($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom,
            5'($urandom_range(0, 31)), $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)));
      tick();
      chk_model("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter: CNT_W, 32, width of retire counter (legal 8..32).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 MEMtoWB_valid  input  1  MEM stage presents a real instruction.
REQ-005 MEMtoWB_PC  input  32  PC of presented instruction.
REQ-006 MEMtoWB_ALUResult  input  32  ALU result / effective load address.
REQ-007 MEMtoWB_ReadData  input  32  raw word read from data memory.
REQ-008 MEMtoWB_WriteReg  input  5  destination register number.
REQ-009 MEMtoWB_RegWrite  input  1  instruction writes the register file.
REQ-010 MEMtoWB_MemtoReg  input  1  1 = write load data, 0 = write ALU result.
REQ-011 MEMtoWB_LoadType  input  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU.
REQ-012 stall  input  1  hold WB register contents.
REQ-013 flush  input  1  replace next WB entry with a bubble.
REQ-014 WBtoID_WriteReg  output  5  register-file write address to ID stage.
REQ-015 WBtoID_WriteData  output  32  register-file write data to ID stage.
REQ-016 WBtoID_RegWrite  output  1  register-file write enable to ID stage.
REQ-017 WB_Valid  output  1  WB register holds a real instruction.
REQ-018 WB_PC  output  32  PC of instruction held in WB.
REQ-019 WB_RetireCount  output  CNT_W  count of instructions captured into WB.

Function
REQ-020 The MEM/WB register (valid, PC, ALUResult, ReadData, WriteReg, RegWrite, MemtoReg, LoadType) shall update on each rising clk edge.
REQ-021 Priority per edge: rst > flush > stall > load.
REQ-022 Flush (rst=0): valid <= 0; other fields don't-care; counter unchanged.
REQ-023 Stall (rst=0, flush=0): all fields and counter hold.
REQ-024 Load: all fields <= MEMtoWB_* inputs; latency exactly one cycle from input to outputs.
REQ-025 All outputs shall be combinational functions of the registered fields only, with no input-to-output path.
REQ-026 Load data extraction shall be big-endian, with byte offset = ALUResult[1:0].
- LB/LBU: offset 0 -> ReadData[31:24], 1 -> [23:16], 2 -> [15:8], 3 -> [7:0]; LB sign-extends, LBU zero-extends.
- LH/LHU: ALUResult[1]=0 -> [31:16], 1 -> [15:0]; ALUResult[0] ignored (no misalign trap); LH sign-extends, LHU zero-extends.
- LW and codes 101-111: full ReadData.
REQ-027 WBtoID_WriteData = extracted load data when MemtoReg=1, else ALUResult.
REQ-028 WBtoID_WriteReg = registered WriteReg, always driven.
REQ-029 WBtoID_RegWrite = valid AND RegWrite AND (WriteReg != 0); writes to $0 are suppressed.
REQ-030 WB_Valid = registered valid; WB_PC = registered PC.
REQ-031 The retire counter shall increment by 1 on each load edge where MEMtoWB_valid=1, regardless of RegWrite, and shall wrap from all-ones to 0.
REQ-032 During stall, WBtoID_RegWrite shall remain at its registered value; the register file tolerates the repeated identical write.

Reset
REQ-033 On a rst=1 edge: valid=0, RegWrite=0, MemtoReg=0, LoadType=000, WriteReg=0, PC=0, ALUResult=0, ReadData=0, counter=0.
REQ-034 Outputs after reset: WBtoID_RegWrite=0, WBtoID_WriteReg=0, WBtoID_WriteData=0, WB_Valid=0, WB_PC=0, WB_RetireCount=0.
REQ-035 rst asserted mid-stall or concurrently with flush shall still apply REQ-033.

Verification
REQ-036 ALU write: valid=1, RegWrite=1, MemtoReg=0, WriteReg=8, ALUResult=0x00000005 -> next cycle RegWrite=1, WriteReg=8, WriteData=0x00000005, count=1.
REQ-037 Loads with ReadData=0x8091A2B3: LB offset 1 -> 0xFFFFFF91; LBU offset 3 -> 0x000000B3; LH offset 0 -> 0xFFFF8091; LHU offset 2 -> 0x0000A2B3; LH offset 3 -> 0xFFFFA2B3.
REQ-038 $0 suppression: RegWrite=1, WriteReg=0 -> WBtoID_RegWrite=0, WB_Valid=1, count increments.
REQ-039 Stall 3 cycles with changing inputs -> outputs and count frozen; release -> new entry appears one cycle later.
REQ-040 flush and stall asserted together with valid input -> next cycle WB_Valid=0, RegWrite=0, count unchanged; rst with stall -> all outputs 0.
REQ-041 CNT_W=8: preload 255 captures, then one more -> count wraps 0xFF -> 0x00.
